masked_sbox_bram_sched: RTL and testbench
=========================================

// Module: masked_sbox_bram_sched
// PURPOSE
//  Round-robin scheduler sharing one dual-port masked S-box BRAM table (BRAM_TDP, 8-bit read,
//  DOA_REG/DOB_REG=1) between NREQ byte-lookup requesters, e.g. state and key-schedule lanes.
//  Grants up to two lookups per cycle (ports A and B) and carries each requester tag through
//  the 2-cycle BRAM latency. Owns BRAM enable/reset; output back-pressure freezes the BRAM pipe.
// PARAMETERS
//  NREQ       4          number of requesters, 2..8
//  AW         10         BRAM address width (share/mask concatenation), 10 for 9Kb x8
//  IDLE_ADDR  10'h000    address driven on a port with no grant (fixed; no share data on idle port)
// PORTS
//  clk          in   1         single clock; all logic on rising edge
//  rst          in   1         synchronous, active-high reset
//  req_valid    in   NREQ      lookup request per requester
//  req_addr     in   NREQ*AW   request address; requester i at [i*AW +: AW]
//  req_ready    out  NREQ      grant; transfer when req_valid[i] & req_ready[i]
//  bram_addra   out  AW        BRAM port A address (combinational from grant)
//  bram_addrb   out  AW        BRAM port B address
//  bram_en      out  1         drives ENA/ENB/REGCEA/REGCEB
//  bram_rst     out  1         drives RSTA/RSTB
//  bram_doa     in   8         BRAM port A data
//  bram_dob     in   8         BRAM port B data
//  res_valid_a  out  1         lane A result valid
//  res_tag_a    out  3         lane A requester index
//  res_data_a   out  8         lane A data (= bram_doa)
//  res_valid_b  out  1         lane B result valid
//  res_tag_b    out  3         lane B requester index
//  res_data_b   out  8         lane B data (= bram_dob)
//  res_ready    in   1         consumer accepts both lanes this cycle
//  busy         out  1         any lookup in flight (stage-1 or stage-2 valid)
// BEHAVIOUR
//  - Reset: rr ptr=0, all tag-stage valids=0, req_ready=0, bram_rst=1, bram_en=1 (so BRAM output
//    regs load SRVAL=0), addra/addrb=IDLE_ADDR; res_valid_*=0, res_tag_*=0. Mid-op reset drops all
//    in-flight lookups; no result for them ever appears.
//  - stall = (res_valid_a | res_valid_b) & ~res_ready. On stall: bram_en=0, req_ready=0, both tag
//    stages and rr hold; BRAM array latch and output regs hold, so res_* stay stable.
//  - No stall: bram_en=1. Scan i = rr, rr+1, ... mod NREQ: first requester with req_valid -> port A,
//    second -> port B. Ungranted port gets IDLE_ADDR and a 0 valid in stage 1.
//  - rr update on any grant: (index of last granted + 1) mod NREQ; unchanged if no grant.
//  - Latency: accepted in cycle t -> res_valid with data in cycle t+2 (no stall); each stall cycle
//    adds one. Throughput 2 lookups/cycle. Lane order: A carries the earlier rr-order grant.
//  - Tag pipeline: stage1 {vld,tag} loaded when bram_en; stage2 <= stage1 when bram_en;
//    res_valid/tag = stage2. res_data passes BRAM data straight through (no extra register).
//  - Single requester valid: granted on A only; B idle. NREQ=2 both valid: 0->A, 1->B, rr stays 0.
//  - Same requester never granted on both ports in one cycle. req_ready is a function of req_valid
//    and rr only (not of res_ready other than via stall).
// STRUCTURE
//  - Shared package: AW, TAGW=3, IDLE_ADDR default, sched_tag_t {vld, tag}.
//  - Sub-module: rr_pick2 (combinational: req_valid, rr -> idx_a, vld_a, idx_b, vld_b).
//  - Top: stall logic, rr register, 2-stage tag pipe, address muxes; BRAM instanced outside.
// TESTING (bench models BRAM with 2-cycle registered read, 1024x8 table = addr[7:0]^8'hA5)
//  - Reset then idle: rst 3 cycles -> res_valid_a/b=0, bram_en=1 during rst, addra=addrb=0 after.
//  - NREQ=4, req 1 only, addr 10'h03C in cycle 5 -> req_ready=4'b0010, addra=10'h03C, addrb=0;
//    cycle 7: res_valid_a=1, tag=1, data=8'h99; res_valid_b=0.
//  - All 4 valid continuously, res_ready=1 -> grants (0,1),(2,3),(0,1)...; rr 0->2->0; 2 results/cycle.
//  - Back-pressure: results pending, res_ready=0 for 3 cycles -> bram_en=0, req_ready=0, res_* frozen;
//    res_ready=1 -> pending pair retires, next pair appears following cycle, no loss/duplication.
//  - Reset mid-flight: grants in cycles t and t+1, rst at t+1 -> no res_valid for either; rr=0 after.
//  - Random req_valid/res_ready 10k cycles -> every accepted (tag,addr) yields exactly one correct
//    result, in per-requester order; max wait per requester <= ceil(NREQ/2) unstalled cycles.

Source files
------------

// File: rtl/masked_sbox_bram_sched_pkg.sv
// Shared types and constants for the masked S-box BRAM lookup scheduler.
package masked_sbox_bram_sched_pkg;

    localparam int SBOX_AW = 10;
    localparam int TAGW = 3;
    localparam int NREQ_MAX = 8;
    localparam logic [SBOX_AW-1:0] IDLE_ADDR_DEFAULT = 10'h000;

    typedef struct packed {
        logic            vld;
        logic [TAGW-1:0] tag;
    } sched_tag_t;

    // An idle slot carries a zero tag so res_tag_* reads 0 whenever res_valid_* is low.
    function automatic sched_tag_t mk_tag(input logic vld, input logic [TAGW-1:0] idx);
        sched_tag_t t;
        t.vld = vld;
        t.tag = vld ? idx : {TAGW{1'b0}};
        return t;
    endfunction

endpackage

// File: rtl/masked_sbox_bram_sched_if.sv
// Request, BRAM and result signal bundle between the scheduler and its neighbours.
interface masked_sbox_bram_sched_if
    import masked_sbox_bram_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = SBOX_AW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic [AW-1:0]      bram_addra;
    logic [AW-1:0]      bram_addrb;
    logic               bram_en;
    logic               bram_rst;
    logic [7:0]         bram_doa;
    logic [7:0]         bram_dob;
    logic               res_valid_a;
    logic [TAGW-1:0]    res_tag_a;
    logic [7:0]         res_data_a;
    logic               res_valid_b;
    logic [TAGW-1:0]    res_tag_b;
    logic [7:0]         res_data_b;
    logic               res_ready;
    logic               busy;

    modport slave (
        input  req_valid, req_addr, bram_doa, bram_dob, res_ready,
        output req_ready, bram_addra, bram_addrb, bram_en, bram_rst,
               res_valid_a, res_tag_a, res_data_a,
               res_valid_b, res_tag_b, res_data_b, busy
    );

    modport master (
        output req_valid, req_addr, bram_doa, bram_dob, res_ready,
        input  req_ready, bram_addra, bram_addrb, bram_en, bram_rst,
               res_valid_a, res_tag_a, res_data_a,
               res_valid_b, res_tag_b, res_data_b, busy
    );

endinterface

// File: rtl/masked_sbox_bram_sched_rr_pick2.sv
// Round-robin picker: first two valid requesters in scan order starting at rr.
module masked_sbox_bram_sched_rr_pick2
    import masked_sbox_bram_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [TAGW-1:0] rr_i,
    output logic [TAGW-1:0] idx_a_o,
    output logic            vld_a_o,
    output logic [TAGW-1:0] idx_b_o,
    output logic            vld_b_o
);

    logic [NREQ_MAX-1:0] valid_pad_s;
    logic [TAGW:0]       pos_s;

    assign valid_pad_s = NREQ_MAX'(req_valid_i);

    // Scan rr, rr+1, ... wrapping at NREQ; lane A takes the first hit, lane B the second.
    always_comb begin
        idx_a_o = {TAGW{1'b0}};
        vld_a_o = 1'b0;
        idx_b_o = {TAGW{1'b0}};
        vld_b_o = 1'b0;
        pos_s   = {(TAGW+1){1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            pos_s = {1'b0, rr_i} + (TAGW+1)'(k);
            if (pos_s >= (TAGW+1)'(NREQ)) begin
                pos_s = pos_s - (TAGW+1)'(NREQ);
            end else begin
                pos_s = pos_s;
            end
            if (valid_pad_s[pos_s[TAGW-1:0]]) begin
                if (!vld_a_o) begin
                    vld_a_o = 1'b1;
                    idx_a_o = pos_s[TAGW-1:0];
                end else if (!vld_b_o) begin
                    vld_b_o = 1'b1;
                    idx_b_o = pos_s[TAGW-1:0];
                end else begin
                    vld_b_o = vld_b_o;
                end
            end else begin
                vld_a_o = vld_a_o;
            end
        end
    end

endmodule

// File: rtl/masked_sbox_bram_sched.sv
// Shares one dual-port registered-output S-box BRAM between NREQ lookup requesters,
// granting up to two lookups per cycle and tracking requester tags across the read latency.
module masked_sbox_bram_sched
    import masked_sbox_bram_sched_pkg::*;
#(
    parameter int            NREQ      = 4,
    parameter int            AW        = SBOX_AW,
    parameter logic [AW-1:0] IDLE_ADDR = AW'(IDLE_ADDR_DEFAULT)
) (
    input logic                      clk,
    input logic                      rst,
    masked_sbox_bram_sched_if.slave  bus
);

    logic [TAGW-1:0] rr_q, rr_d;
    sched_tag_t      s1a_q, s1b_q, s2a_q, s2b_q;
    sched_tag_t      s1a_d, s1b_d;
    logic            stall_s, en_s, grant_a_s, grant_b_s;
    logic [TAGW-1:0] idx_a_s, idx_b_s;
    logic            vld_a_s, vld_b_s;
    logic [NREQ-1:0] ready_s;
    logic [AW-1:0]   addr_tab_s [NREQ_MAX];

    function automatic logic [TAGW-1:0] rr_next(input logic [TAGW-1:0] idx);
        if (idx == TAGW'(NREQ - 1)) begin
            return {TAGW{1'b0}};
        end else begin
            return idx + TAGW'(1);
        end
    endfunction

    masked_sbox_bram_sched_rr_pick2 #(.NREQ(NREQ)) u_pick (
        .req_valid_i (bus.req_valid),
        .rr_i        (rr_q),
        .idx_a_o     (idx_a_s),
        .vld_a_o     (vld_a_s),
        .idx_b_o     (idx_b_s),
        .vld_b_o     (vld_b_s)
    );

    for (genvar g = 0; g < NREQ_MAX; g++) begin : g_addr
        if (g < NREQ) begin : g_on
            assign addr_tab_s[g] = bus.req_addr[g*AW +: AW];
        end else begin : g_off
            assign addr_tab_s[g] = IDLE_ADDR;
        end
    end

    // Back-pressure freezes the whole BRAM pipe; reset keeps it enabled so the output regs clear.
    assign stall_s   = (s2a_q.vld | s2b_q.vld) & ~bus.res_ready;
    assign en_s      = rst | ~stall_s;
    assign grant_a_s = vld_a_s & ~stall_s & ~rst;
    assign grant_b_s = vld_b_s & ~stall_s & ~rst;

    // Grant vector: one-hot per lane, never the same requester twice.
    always_comb begin
        ready_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if ((grant_a_s && (idx_a_s == TAGW'(i))) || (grant_b_s && (idx_b_s == TAGW'(i)))) begin
                ready_s[i] = 1'b1;
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    // Next round-robin pointer and stage-1 tags from this cycle's grants.
    always_comb begin
        rr_d  = rr_q;
        s1a_d = mk_tag(grant_a_s, idx_a_s);
        s1b_d = mk_tag(grant_b_s, idx_b_s);
        if (grant_b_s) begin
            rr_d = rr_next(idx_b_s);
        end else if (grant_a_s) begin
            rr_d = rr_next(idx_a_s);
        end else begin
            rr_d = rr_q;
        end
    end

    // Pointer and two-stage tag pipe, advancing in lockstep with the BRAM enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q  <= {TAGW{1'b0}};
            s1a_q <= mk_tag(1'b0, {TAGW{1'b0}});
            s1b_q <= mk_tag(1'b0, {TAGW{1'b0}});
            s2a_q <= mk_tag(1'b0, {TAGW{1'b0}});
            s2b_q <= mk_tag(1'b0, {TAGW{1'b0}});
        end else if (en_s) begin
            rr_q  <= rr_d;
            s1a_q <= s1a_d;
            s1b_q <= s1b_d;
            s2a_q <= s1a_q;
            s2b_q <= s1b_q;
        end
    end

    assign bus.req_ready   = ready_s;
    assign bus.bram_addra  = grant_a_s ? addr_tab_s[idx_a_s] : IDLE_ADDR;
    assign bus.bram_addrb  = grant_b_s ? addr_tab_s[idx_b_s] : IDLE_ADDR;
    assign bus.bram_en     = en_s;
    assign bus.bram_rst    = rst;
    assign bus.res_valid_a = s2a_q.vld;
    assign bus.res_tag_a   = s2a_q.tag;
    assign bus.res_data_a  = bus.bram_doa;
    assign bus.res_valid_b = s2b_q.vld;
    assign bus.res_tag_b   = s2b_q.tag;
    assign bus.res_data_b  = bus.bram_dob;
    assign bus.busy        = s1a_q.vld | s1b_q.vld | s2a_q.vld | s2b_q.vld;

endmodule

// File: tb/tb_masked_sbox_bram_sched.sv
// Randomized and directed bench for masked_sbox_bram_sched against a queue-based reference model.
module tb_masked_sbox_bram_sched;
    import masked_sbox_bram_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int AWL  = 10;
    localparam int WMAX = (NREQ + 1) / 2;

    typedef struct {
        int             tag;
        logic [AWL-1:0] addr;
        int             ts;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    masked_sbox_bram_sched_if #(.NREQ(NREQ), .AW(AWL)) bus_if ();
    masked_sbox_bram_sched #(.NREQ(NREQ), .AW(AWL)) dut (.clk(clk), .rst(rst), .bus(bus_if.slave));

    // BRAM stand-in: address latch then output register, both gated by enable.
    logic [7:0] lat_a, lat_b;
    function automatic logic [7:0] tbl(input logic [AWL-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction
    always @(posedge clk) begin
        if (bus_if.bram_en) begin
            lat_a           <= tbl(bus_if.bram_addra);
            lat_b           <= tbl(bus_if.bram_addrb);
            bus_if.bram_doa <= bus_if.bram_rst ? 8'h00 : lat_a;
            bus_if.bram_dob <= bus_if.bram_rst ? 8'h00 : lat_b;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_q[$];
    int rr_m = 0;
    int ecnt = 0;
    int ga_m, gb_m;
    logic stall_m = 1'b0;
    logic prev_stall = 1'b0;
    logic [23:0] snap;
    int wait_cnt [NREQ];
    logic [NREQ-1:0] rv = '0;
    logic [NREQ-1:0] acc = '0;
    logic [AWL-1:0] ra [NREQ];
    logic rres = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void pick(input logic [NREQ-1:0] v, input int rr, output int a, output int b);
        a = -1;
        b = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i = (rr + k) % NREQ;
            if (v[i]) begin
                if (a < 0) a = i;
                else if (b < 0) b = i;
            end
        end
    endfunction

    task automatic apply();
        bus_if.req_valid = rv;
        for (int i = 0; i < NREQ; i++) bus_if.req_addr[i*AWL +: AWL] = ra[i];
        bus_if.res_ready = rres;
    endtask

    task automatic pop(input logic [2:0] tag, input logic [7:0] data, input string lane);
        int idx = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j].tag == int'(tag)) begin
                idx = j;
                break;
            end
        end
        check_val({lane, "_found"}, 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
            check_val({lane, "_data"}, 32'(data), 32'(exp_q[idx].addr[7:0] ^ 8'hA5));
            check_val({lane, "_latency"}, 32'(ecnt - exp_q[idx].ts), 32'd2);
            exp_q.delete(idx);
        end
    endtask

    task automatic sample();
        logic [NREQ-1:0] er;
        logic [AWL-1:0] ea, eb;
        #1;
        ga_m = -1;
        gb_m = -1;
        if (rst) begin
            check_val("rst_bram_en", 32'(bus_if.bram_en), 32'd1);
            check_val("rst_bram_rst", 32'(bus_if.bram_rst), 32'd1);
            check_val("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
            exp_q.delete();
            rr_m = 0;
            acc = '0;
            stall_m = 1'b0;
            prev_stall = 1'b0;
            for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        end else begin
            stall_m = (bus_if.res_valid_a | bus_if.res_valid_b) & ~rres;
            check_val("bram_rst", 32'(bus_if.bram_rst), 32'd0);
            check_val("bram_en", 32'(bus_if.bram_en), 32'(!stall_m));
            er = '0;
            ea = '0;
            eb = '0;
            if (!stall_m) begin
                pick(rv, rr_m, ga_m, gb_m);
                if (ga_m >= 0) begin er[ga_m] = 1'b1; ea = ra[ga_m]; end
                if (gb_m >= 0) begin er[gb_m] = 1'b1; eb = ra[gb_m]; end
            end
            check_val("req_ready", 32'(bus_if.req_ready), 32'(er));
            check_val("addra", 32'(bus_if.bram_addra), 32'(ea));
            check_val("addrb", 32'(bus_if.bram_addrb), 32'(eb));
            if (prev_stall) begin
                check_val("frozen", {8'd0, bus_if.res_valid_a, bus_if.res_tag_a, bus_if.res_data_a,
                                     bus_if.res_valid_b, bus_if.res_tag_b, bus_if.res_data_b}, {8'd0, snap});
            end
            if (rres) begin
                if (bus_if.res_valid_a) pop(bus_if.res_tag_a, bus_if.res_data_a, "lane_a");
                if (bus_if.res_valid_b) pop(bus_if.res_tag_b, bus_if.res_data_b, "lane_b");
            end
            acc = rv & bus_if.req_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) exp_q.push_back('{tag: i, addr: ra[i], ts: ecnt});
                if (!stall_m && rv[i]) begin
                    wait_cnt[i]++;
                    if (acc[i]) begin
                        check_val("wait_bound", 32'(wait_cnt[i] <= WMAX), 32'd1);
                        wait_cnt[i] = 0;
                    end
                end
            end
            prev_stall = stall_m;
            snap = {bus_if.res_valid_a, bus_if.res_tag_a, bus_if.res_data_a,
                    bus_if.res_valid_b, bus_if.res_tag_b, bus_if.res_data_b};
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst && !stall_m) begin
            ecnt++;
            if (gb_m >= 0) rr_m = (gb_m + 1) % NREQ;
            else if (ga_m >= 0) rr_m = (ga_m + 1) % NREQ;
        end
        @(negedge clk);
    endtask

    task automatic refill();
        for (int i = 0; i < NREQ; i++) if (acc[i]) ra[i] = AWL'($urandom);
    endtask

    task automatic step();
        apply();
        sample();
        advance();
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            wait_cnt[i] = 0;
        end
        rst = 1'b1;
        apply();
        @(negedge clk);

        // Reset, then idle.
        for (int c = 0; c < 3; c++) begin
            apply(); sample();
            check_val("rst_res_valid_a", 32'(bus_if.res_valid_a), 32'd0);
            check_val("rst_res_valid_b", 32'(bus_if.res_valid_b), 32'd0);
            check_val("rst_res_tag_a", 32'(bus_if.res_tag_a), 32'd0);
            advance();
        end
        rst = 1'b0;
        apply(); sample();
        check_val("idle_addra", 32'(bus_if.bram_addra), 32'h000);
        check_val("idle_addrb", 32'(bus_if.bram_addrb), 32'h000);
        check_val("idle_busy", 32'(bus_if.busy), 32'd0);
        advance();

        // Single requester 1 at 0x03C.
        rv = 4'b0010; ra[1] = 10'h03C;
        apply(); sample();
        check_val("single_ready", 32'(bus_if.req_ready), 32'h2);
        check_val("single_addra", 32'(bus_if.bram_addra), 32'h03C);
        check_val("single_addrb", 32'(bus_if.bram_addrb), 32'h000);
        advance();
        rv = '0;
        step();
        apply(); sample();
        check_val("single_res_valid_a", 32'(bus_if.res_valid_a), 32'd1);
        check_val("single_res_tag_a", 32'(bus_if.res_tag_a), 32'd1);
        check_val("single_res_data_a", 32'(bus_if.res_data_a), 32'h99);
        check_val("single_res_valid_b", 32'(bus_if.res_valid_b), 32'd0);
        advance();

        // All requesters valid, then back-pressure.
        rst = 1'b1; step(); rst = 1'b0;
        rv = 4'b1111;
        for (int i = 0; i < NREQ; i++) ra[i] = AWL'($urandom);
        apply(); sample(); check_val("full_ready0", 32'(bus_if.req_ready), 32'h3); advance(); refill();
        apply(); sample(); check_val("full_ready1", 32'(bus_if.req_ready), 32'hC); advance(); refill();
        apply(); sample(); check_val("full_ready2", 32'(bus_if.req_ready), 32'h3);
        check_val("full_pair_valid", 32'({bus_if.res_valid_a, bus_if.res_valid_b}), 32'h3);
        check_val("full_pair_tags", 32'({bus_if.res_tag_a, bus_if.res_tag_b}), 32'({3'd0, 3'd1}));
        advance(); refill();
        rres = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply(); sample();
            check_val("bp_bram_en", 32'(bus_if.bram_en), 32'd0);
            check_val("bp_ready", 32'(bus_if.req_ready), 32'd0);
            check_val("bp_tags", 32'({bus_if.res_tag_a, bus_if.res_tag_b}), 32'({3'd2, 3'd3}));
            advance();
        end
        rres = 1'b1;
        apply(); sample();
        check_val("bp_release_tags", 32'({bus_if.res_tag_a, bus_if.res_tag_b}), 32'({3'd2, 3'd3}));
        check_val("bp_release_ready", 32'(bus_if.req_ready), 32'hC);
        advance(); refill();
        apply(); sample();
        check_val("bp_next_valid", 32'({bus_if.res_valid_a, bus_if.res_valid_b}), 32'h3);
        check_val("bp_next_tags", 32'({bus_if.res_tag_a, bus_if.res_tag_b}), 32'({3'd0, 3'd1}));
        advance(); refill();
        rv = '0;
        for (int c = 0; c < 4; c++) step();

        // Reset while lookups are in flight.
        rv = 4'b0001; ra[0] = AWL'($urandom);
        apply(); sample(); check_val("mid_ready", 32'(bus_if.req_ready), 32'h1); advance();
        rv = 4'b0010; ra[1] = AWL'($urandom); rst = 1'b1;
        step();
        rst = 1'b0; rv = '0;
        for (int c = 0; c < 3; c++) begin
            apply(); sample();
            check_val("mid_no_res_a", 32'(bus_if.res_valid_a), 32'd0);
            check_val("mid_no_res_b", 32'(bus_if.res_valid_b), 32'd0);
            advance();
        end
        rv = 4'b1111;
        apply(); sample(); check_val("mid_rr_zero", 32'(bus_if.req_ready), 32'h3); advance();
        rv = '0;

        // Random traffic with random back-pressure.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) rv[i] = 1'b0;
                if (!rv[i] && ($urandom_range(0, 2) == 0)) begin
                    rv[i] = 1'b1;
                    ra[i] = AWL'($urandom);
                end
            end
            rres = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain.
        rv = '0; rres = 1'b1;
        for (int c = 0; c < 6; c++) step();
        check_val("drain_empty", 32'(exp_q.size()), 32'd0);
        check_val("drain_busy", 32'(bus_if.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
